// File: rtl/gpio_wb_arbiter.sv
// Round-robin arbiter that shares the GPIO Wishbone slave among NREQ requesters.
// Optional watchdog: define GPIO_ARB_TIMEOUT_EN to end a stalled cycle with err_o after TIMEOUT_CYCLES.

module gpio_wb_arbiter_lane #(
   parameter int NREQ = 2,
   parameter int LW   = 1,
   parameter int IDX  = 0
) (
   input  logic [LW-1:0] last_i,
   output logic [LW-1:0] dist_o
);
   // Priority distance counted from the slot after last_i; smallest distance wins.
   always_comb dist_o = LW'((IDX + NREQ - 1 - int'(last_i)) % NREQ);
endmodule

module gpio_wb_arbiter #(
   parameter int NREQ           = 2,
   parameter int AW             = 4,
   parameter int DW             = 8,
   parameter int SW             = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ-1:0]      req_we_i,
   input  logic [NREQ*AW-1:0]   req_adr_i,
   input  logic [NREQ*DW-1:0]   req_dat_i,
   input  logic [NREQ*SW-1:0]   req_sel_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 err_o,
   output logic [DW-1:0]        rdat_o,
   output logic                 busy_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [AW-1:0]        wb_adr_o,
   output logic [DW-1:0]        wb_dat_o,
   output logic [SW-1:0]        wb_sel_o,
   input  logic [DW-1:0]        wb_dat_i,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i
);
   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
   } wb_req_t;

   typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

   if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("gpio_wb_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES >= 1");
   end

   state_t                  state_q, state_d;
   logic [LW-1:0]           last_q, last_d;
   logic [NREQ-1:0]         gnt_q, gnt_d;
   logic [NREQ-1:0]         done_q, done_d;
   logic                    err_q, err_d;
   logic [DW-1:0]           rdat_q, rdat_d;
   logic                    cyc_q, cyc_d;
   wb_req_t                 req_q, req_d;
   logic                    tmo;

   wb_req_t [NREQ-1:0]       lane_req;
   logic [NREQ-1:0][LW-1:0]  lane_dist;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign lane_req[g] = {req_we_i[g], req_adr_i[g*AW +: AW],
                            req_dat_i[g*DW +: DW], req_sel_i[g*SW +: SW]};
      gpio_wb_arbiter_lane #(.NREQ(NREQ), .LW(LW), .IDX(g)) u_lane (
         .last_i (last_q),
         .dist_o (lane_dist[g])
      );
   end

   logic                win_vld;
   logic [LW-1:0]       win_idx;
   logic [LW-1:0]       win_dist;
   logic [NREQ-1:0]     win_oh;
   wb_req_t             win_req;

   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_dist = '0;
      win_oh   = '0;
      win_req  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i] && (!win_vld || lane_dist[i] < win_dist)) begin
            win_vld   = 1'b1;
            win_idx   = LW'(i);
            win_dist  = lane_dist[i];
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_req   = lane_req[i];
         end
      end
   end

`ifdef GPIO_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // cnt_q holds (stb cycle - 1), so the limit hits on the last allowed stb cycle.
   assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      cyc_d   = cyc_q;
      req_d   = req_q;
      done_d  = '0;
      err_d   = 1'b0;
      rdat_d  = rdat_q;
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               req_d   = win_req;
               gnt_d   = win_oh;
               cyc_d   = 1'b1;
               last_d  = win_idx;
               state_d = BUS;
`ifdef GPIO_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         BUS: begin
            if (wb_ack_i || wb_err_i || tmo) begin
               state_d = IDLE;
               cyc_d   = 1'b0;
               gnt_d   = '0;
               done_d  = gnt_q;
               // Without ack this is either a bus error or the watchdog firing.
               err_d   = wb_err_i || !wb_ack_i;
               if (wb_ack_i && !wb_err_i && !req_q.we) rdat_d = wb_dat_i;
            end
`ifdef GPIO_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= LW'(NREQ - 1);
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
         cyc_q   <= 1'b0;
         req_q   <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
         cyc_q   <= cyc_d;
         req_q   <= req_d;
`ifdef GPIO_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt_o    = gnt_q;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign rdat_o   = rdat_q;
   assign busy_o   = cyc_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = req_q.we;
   assign wb_adr_o = req_q.adr;
   assign wb_dat_o = req_q.dat;
   assign wb_sel_o = req_q.sel;
endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Scoreboard bench for gpio_wb_arbiter: directed requests, a scripted slave, and a monitor
// that checks each grant and completion against queued expectations.
module tb_gpio_wb_arbiter;
   localparam int NREQ = 2, AW = 4, DW = 8, SW = 4;

   logic                wb_clk_i = 1'b0;
   logic                wb_rst_i = 1'b0;
   logic [NREQ-1:0]     req_i = '0, req_we_i = '0;
   logic [NREQ*AW-1:0]  req_adr_i = '0;
   logic [NREQ*DW-1:0]  req_dat_i = '0;
   logic [NREQ*SW-1:0]  req_sel_i = '0;
   logic [NREQ-1:0]     gnt_o, done_o;
   logic                err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o;
   logic [DW-1:0]       rdat_o, wb_dat_o;
   logic [AW-1:0]       wb_adr_o;
   logic [SW-1:0]       wb_sel_o;
   logic [DW-1:0]       wb_dat_i = '0;
   logic                wb_ack_i = 1'b0, wb_err_i = 1'b0;

   gpio_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i),
      .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdat_o(rdat_o), .busy_o(busy_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic            we;
      logic [AW-1:0]   adr;
      logic [DW-1:0]   dat;
      logic [SW-1:0]   sel;
   } gexp_t;

   typedef struct packed {
      logic [NREQ-1:0] done;
      logic            err;
      logic [DW-1:0]   rdat;
   } dexp_t;

   gexp_t exp_g[$];
   int    exp_gap[$];
   dexp_t exp_d[$];

   int checks = 0, failures = 0;
   int cyc_n = 0, done_cnt = 0, last_done_cyc = -100, stb_run = 0, last_stb_len = 0;
   logic            prev_cyc = 1'b0;
   logic [NREQ-1:0] prev_done = '0;

   // slave script: mode 0 ack, 1 err, 2 ack+err, 3 never answer
   int        slv_lat = 1, slv_mode = 0, slv_cnt = 0;
   logic [DW-1:0] slv_rdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge wb_clk_i);
         wb_dat_i = slv_rdata;
         if (wb_cyc_o && wb_stb_o) begin
            slv_cnt++;
            wb_ack_i = (slv_cnt == slv_lat) && (slv_mode == 0 || slv_mode == 2);
            wb_err_i = (slv_cnt == slv_lat) && (slv_mode == 1 || slv_mode == 2);
         end else begin
            slv_cnt  = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
         end
      end
   end

   initial begin
      gexp_t g;
      dexp_t d;
      int    gap;
      forever begin
         @(negedge wb_clk_i);
         cyc_n++;
         chk("err_without_done", err_o && (done_o == '0), 0);
         chk("bus_ctrl_consistent",
             (wb_stb_o == wb_cyc_o) && (busy_o == wb_cyc_o) &&
             (wb_cyc_o ? $onehot(gnt_o) : (gnt_o == '0)), 1);
         chk("done_one_cycle", (done_o != '0) && (prev_done != '0), 0);
         if (wb_cyc_o && !prev_cyc) begin
            if (exp_g.size() == 0) begin
               chk("unexpected_grant", {gnt_o, wb_adr_o}, 0);
            end else begin
               g   = exp_g.pop_front();
               gap = exp_gap.pop_front();
               chk("grant_bus", {gnt_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, g);
               if (gap > 0) chk("idle_gap", cyc_n - last_done_cyc, gap);
            end
         end
         if (done_o != '0) begin
            done_cnt++;
            last_done_cyc = cyc_n;
            if (exp_d.size() == 0) begin
               chk("unexpected_done", {done_o, err_o, rdat_o}, 0);
            end else begin
               d = exp_d.pop_front();
               chk("done_resp", {done_o, err_o, rdat_o}, d);
            end
         end
         if (wb_stb_o) stb_run++;
         else if (stb_run > 0) begin
            last_stb_len = stb_run;
            stb_run      = 0;
         end
         prev_cyc  = wb_cyc_o;
         prev_done = done_o;
      end
   end

   task automatic tick();
      @(negedge wb_clk_i);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [SW-1:0] sel);
      req_we_i[i]            = we;
      req_adr_i[i*AW +: AW]  = adr;
      req_dat_i[i*DW +: DW]  = dat;
      req_sel_i[i*SW +: SW]  = sel;
   endtask

   task automatic wait_done(input int n, input int max_cyc, input string name);
      int tgt, k;
      tgt = done_cnt + n;
      k   = 0;
      while (done_cnt < tgt && k < max_cyc) begin
         tick();
         k++;
      end
      chk(name, done_cnt, tgt);
   endtask

   function automatic logic [63:0] all_outs();
      return {gnt_o, done_o, err_o, rdat_o, busy_o, wb_cyc_o, wb_stb_o,
              wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      repeat (3) tick();
      chk("reset_outputs", all_outs(), 0);
      wb_rst_i = 1'b1;
      tick();

      // single zero-wait read, exact cycle positions
      slv_lat = 1; slv_mode = 0; slv_rdata = 8'hA5;
      set_req(0, 1'b0, 4'h3, 8'h00, 4'hF);
      exp_g.push_back(gexp_t'({2'b01, 1'b0, 4'h3, 8'h00, 4'hF})); exp_gap.push_back(0);
      exp_d.push_back(dexp_t'({2'b01, 1'b0, 8'hA5}));
      req_i = 2'b01;
      tick();
      chk("t1_cycle2", {wb_cyc_o, gnt_o, done_o}, {1'b1, 2'b01, 2'b00});
      tick();
      chk("t1_cycle3", {wb_cyc_o, done_o, err_o, rdat_o}, {1'b0, 2'b01, 1'b0, 8'hA5});
      chk("t1_stb_len", last_stb_len, 1);
      req_i = 2'b00;
      tick();

      // ack and err together on a read: err wins, rdat unchanged
      slv_lat = 2; slv_mode = 2; slv_rdata = 8'h5A;
      set_req(1, 1'b0, 4'h7, 8'h3C, 4'h3);
      exp_g.push_back(gexp_t'({2'b10, 1'b0, 4'h7, 8'h3C, 4'h3})); exp_gap.push_back(0);
      exp_d.push_back(dexp_t'({2'b10, 1'b1, 8'hA5}));
      req_i = 2'b10;
      wait_done(1, 20, "err_wait");
      req_i = 2'b00;
      tick();

      // contention: both held, alternate 0,1,0,1 with one idle cycle between
      slv_lat = 2; slv_mode = 0; slv_rdata = 8'hEE;
      set_req(0, 1'b1, 4'h1, 8'h11, 4'h1);
      set_req(1, 1'b1, 4'h2, 8'h22, 4'h2);
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) exp_g.push_back(gexp_t'({2'b01, 1'b1, 4'h1, 8'h11, 4'h1}));
         else            exp_g.push_back(gexp_t'({2'b10, 1'b1, 4'h2, 8'h22, 4'h2}));
         exp_gap.push_back(k == 0 ? 0 : 1);
         exp_d.push_back(dexp_t'({(k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 8'hA5}));
      end
      req_i = 2'b11;
      wait_done(4, 60, "contention_wait");
      req_i = 2'b00;
      repeat (2) tick();

      // ack on the 16th stb cycle completes normally in either build
      slv_lat = 16; slv_mode = 0; slv_rdata = 8'h77;
      set_req(0, 1'b0, 4'h5, 8'h00, 4'hF);
      exp_g.push_back(gexp_t'({2'b01, 1'b0, 4'h5, 8'h00, 4'hF})); exp_gap.push_back(0);
      exp_d.push_back(dexp_t'({2'b01, 1'b0, 8'h77}));
      req_i = 2'b01;
      wait_done(1, 40, "ack16_wait");
      chk("ack16_stb_len", last_stb_len, 16);
      req_i = 2'b00;
      tick();

      // requester drops its request mid-transaction
      slv_lat = 3; slv_mode = 0; slv_rdata = 8'h3C;
      set_req(0, 1'b0, 4'h4, 8'h00, 4'hF);
      exp_g.push_back(gexp_t'({2'b01, 1'b0, 4'h4, 8'h00, 4'hF})); exp_gap.push_back(0);
      exp_d.push_back(dexp_t'({2'b01, 1'b0, 8'h3C}));
      req_i = 2'b01;
      tick();
      chk("drop_busy", busy_o, 1);
      req_i = 2'b00;
      wait_done(1, 20, "drop_wait");
      repeat (4) tick();
      chk("drop_no_regrant", {busy_o, gnt_o}, 0);

      // slave never answers
      slv_mode = 3;
      set_req(1, 1'b0, 4'h9, 8'h00, 4'hF);
      exp_g.push_back(gexp_t'({2'b10, 1'b0, 4'h9, 8'h00, 4'hF})); exp_gap.push_back(0);
`ifdef GPIO_ARB_TIMEOUT_EN
      exp_d.push_back(dexp_t'({2'b10, 1'b1, 8'h3C}));
      req_i = 2'b10;
      wait_done(1, 40, "timeout_wait");
      chk("timeout_stb_len", last_stb_len, 16);
      req_i = 2'b00;
      tick();
`else
      base  = done_cnt;
      req_i = 2'b10;
      repeat (120) tick();
      chk("no_timeout_done", done_cnt, base);
      chk("no_timeout_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
      chk("no_timeout_long", stb_run >= 100, 1);
      wb_rst_i = 1'b0;
      #1;
      chk("stall_reset_outputs", all_outs(), 0);
      req_i = 2'b00;
      tick();
      wb_rst_i = 1'b1;
      tick();
`endif

      // reset in the middle of a bus cycle
      slv_mode = 3;
      set_req(0, 1'b0, 4'h6, 8'h00, 4'hF);
      exp_g.push_back(gexp_t'({2'b01, 1'b0, 4'h6, 8'h00, 4'hF})); exp_gap.push_back(0);
      req_i = 2'b01;
      repeat (3) tick();
      chk("pre_reset_busy", busy_o, 1);
      wb_rst_i = 1'b0;
      #1;
      chk("mid_reset_outputs", all_outs(), 0);
      slv_mode = 0; slv_lat = 1; slv_rdata = 8'h99;
      set_req(1, 1'b0, 4'h2, 8'h00, 4'h1);
      exp_g.push_back(gexp_t'({2'b10, 1'b0, 4'h2, 8'h00, 4'h1})); exp_gap.push_back(0);
      exp_d.push_back(dexp_t'({2'b10, 1'b0, 8'h99}));
      req_i = 2'b10;
      tick();
      wb_rst_i = 1'b1;
      wait_done(1, 20, "post_reset_wait");
      req_i = 2'b00;
      repeat (3) tick();

      chk("queues_drained", exp_g.size() + exp_d.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
